// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: shares the register-file write port between two requesters using
// sticky priority bounded by MAX_BURST. The write and the forwarding outputs are registered.
module regfile_write_arbiter #(
    parameter int ADDR_W    = 5,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              pend_valid,
    output logic [ADDR_W-1:0] pend_addr
);
    localparam logic [3:0] MAX_B = 4'(MAX_BURST);
    logic              last_grant_q, last_grant_d;
    logic [3:0]        burst_cnt_q, burst_cnt_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              sel, gnt0, gnt1, xfer;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_data;

    // sel is the requester that wins under contention; it flips once the burst is exhausted
    always_comb begin
        sel          = (burst_cnt_q < MAX_B) ? last_grant_q : ~last_grant_q;
        gnt0         = rst_n & req0_valid & (~req1_valid | ~sel);
        gnt1         = rst_n & req1_valid & (~req0_valid | sel);
        xfer         = gnt0 | gnt1;
        win_addr     = gnt1 ? req1_addr : req0_addr;
        win_data     = gnt1 ? req1_data : req0_data;
        last_grant_d = xfer ? gnt1 : last_grant_q;
        burst_cnt_d  = !xfer ? burst_cnt_q :
                       (gnt1 != last_grant_q) ? 4'd1 :
                       (burst_cnt_q < MAX_B) ? burst_cnt_q + 4'd1 : MAX_B;
        wr_en_d      = xfer && (win_addr != '0);
        wr_addr_d    = wr_en_d ? win_addr : wr_addr_q;
        wr_data_d    = wr_en_d ? win_data : wr_data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= 1'b0;
            burst_cnt_q  <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            burst_cnt_q  <= burst_cnt_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
        end
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign pend_valid = wr_en_q;
    assign pend_addr  = wr_addr_q;
endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the single register-file write port between two write-back requesters: req 0 is the pipeline write-back and req 1 is the load/debug/other-core path.
- Uses a valid/ready handshake per requester.
- Priority is sticky, with a bounded burst before the grant must yield.
- Outputs are registered and drive the register file's write enable, write address and write data directly. It also exports the in-flight write so read-side forwarding can use it.

Parameters:
- ADDR_W, 5, register address width.
- DATA_W, 32, write data width.
- MAX_BURST, 4, maximum consecutive grants to one requester while the other is waiting; legal range 1..15.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- req0_valid  in  1  requester 0 has a write pending.
- req0_addr  in  ADDR_W  requester 0 destination register.
- req0_data  in  DATA_W  requester 0 write data.
- req0_ready  out  1  requester 0 granted this cycle.
- req1_valid  in  1  requester 1 has a write pending.
- req1_addr  in  ADDR_W  requester 1 destination register.
- req1_data  in  DATA_W  requester 1 write data.
- req1_ready  out  1  requester 1 granted this cycle.
- wr_en  out  1  register-file write enable (registered).
- wr_addr  out  ADDR_W  register-file write address (registered).
- wr_data  out  DATA_W  register-file write data (registered).
- pend_valid  out  1  equal to wr_en; a write lands at the next clk edge.
- pend_addr  out  ADDR_W  equal to wr_addr, for forwarding comparators.

Behaviour:
- Reset (async, rst_n=0):
  - wr_en=0, wr_addr=0, wr_data=0.
  - last_grant=0, burst_cnt=0.
  - req*_ready=0 while reset is asserted.
  - Reset mid-burst or mid-write discards the pending write; nothing is written after reset releases.
- Grant (combinational from the current valids, last_grant and burst_cnt). At most one ready is high per cycle; ready is never high without its valid.
  - Only one valid: grant it, regardless of burst_cnt.
  - Both valid and burst_cnt < MAX_BURST: grant last_grant.
  - Both valid and burst_cnt == MAX_BURST: grant the other requester.
  - Neither valid: no grant.
- Transfer: occurs when valid && ready. The requester must hold addr/data stable while valid && !ready.
- State update at the clk edge of a transfer:
  - Same requester as last_grant: burst_cnt = min(burst_cnt+1, MAX_BURST).
  - Different requester: last_grant flips and burst_cnt = 1.
  - No transfer: last_grant and burst_cnt hold.
- Output register:
  - At the clk edge of a transfer with addr != 0: wr_en=1, wr_addr/wr_data = the granted requester's values.
  - Otherwise wr_en=0, and wr_addr/wr_data hold their previous values.
  - Latency: accept at edge N gives wr_en high during cycle N+1, and the register file commits at edge N+1.
- Address 0: the transfer is accepted and counts for arbitration, but wr_en stays 0 (the write is silently dropped).
- Both requesters targeting the same address in the same cycle: only the winner transfers. The loser retries and writes later, so the loser's value is the final one.
- Back-to-back transfers: one per cycle, with no bubbles, while any valid is high.
- MAX_BURST=1 gives strict alternation under continuous contention.
- Worst-case wait for a requester that holds valid: MAX_BURST cycles.

Test Plan:
- Reset, then req0 only: req0_valid=1, addr=3, data=0xDEADBEEF → req0_ready=1 same cycle; next cycle wr_en=1, wr_addr=3, wr_data=0xDEADBEEF; cycle after wr_en=0.
- Continuous contention, MAX_BURST=4: req0 and req1 valid every cycle → grant sequence 0,0,0,0,1,1,1,1,0…; wr_en high every cycle, no bubbles.
- Address-0 drop: req1 addr=0, data=0x1234 → req1_ready=1 and burst state updates; wr_en stays 0; a subsequent req0 write to addr 5 still appears with 1-cycle latency.
- Same-address collision: both valid, addr=7, req0 data=0xAAAA, req1 data=0xBBBB, from reset with MAX_BURST=1 → req0 granted, then req1; wr_data sequence 0xAAAA then 0xBBBB at addr 7.
- Async reset mid-burst: rst_n low for half a cycle after the 2nd of 4 grants → wr_en=0 immediately; after release, the first contended grant goes to req0 with burst_cnt=1.
- Valid drop while waiting: req1 valid during req0 burst_cnt=2, req0 valid deasserts → req1 granted next cycle; when both re-assert, req1 keeps the grant up to MAX_BURST.
